// File: rtl/rl_ram_arb_pkg.sv
// Shared types and sizing helpers for the two-port RAM arbiter front end.
//   port_idx_t : selects one of the two requesters (0 = core, 1 = DMA/debug)
//   be_w()     : byte-enable width for a given data width
//   cnt_w()    : response FIFO occupancy counter width (holds 0..depth)
package rl_ram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic port_idx_t;

  function automatic int be_w(input int dbits);
    return (dbits + 7) / 8;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rl_ram_arb_rspq.sv
// Per-port read response queue: DEPTH-entry sync FIFO with a bypass path.
// When empty, an arriving RAM word is presented straight to the consumer and
// is only stored if the consumer does not take it that same cycle.
//   clk_i      : clock, rising edge
//   clr_i      : synchronous clear (pointers and count to zero)
//   in_vld_i   : RAM read data for this port arrives this cycle
//   in_data_i  : RAM read data
//   out_rdy_i  : consumer accepts the presented word
//   out_vld_o  : word presented (bypass or FIFO head)
//   out_data_o : presented word
//   push_o     : word written into storage this cycle
//   pop_o      : stored head removed this cycle
//   count_o    : stored words (0..DEPTH)
module rl_ram_arb_rspq
  import rl_ram_arb_pkg::*;
#(
  parameter  int DBITS = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             in_vld_i,
  input  logic [DBITS-1:0] in_data_i,
  input  logic             out_rdy_i,
  output logic             out_vld_o,
  output logic [DBITS-1:0] out_data_o,
  output logic             push_o,
  output logic             pop_o,
  output logic [CW-1:0]    count_o
);

  logic [DBITS-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             empty;

  assign empty      = (count == '0);
  assign out_vld_o  = ~empty | in_vld_i;
  assign out_data_o = empty ? in_data_i : mem[rptr];
  // Bypassed word consumed in its arrival cycle never touches storage.
  assign push_o     = in_vld_i & ~(empty & out_rdy_i);
  assign pop_o      = ~empty & out_rdy_i;
  assign count_o    = count;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_o) begin
        mem[wptr] <= in_data_i;
        wptr      <= wptr + 1'b1;
      end
      if (pop_o) rptr <= rptr + 1'b1;
      count <= count + CW'(push_o) - CW'(pop_o);
    end
  end

endmodule

// File: rtl/rl_ram_1rw_arb.sv
// Two-requester round-robin front end for a 1RW single-port RAM.
// Grants are combinational; a read is granted only if its port's response
// queue has room for it (stored words + word in flight < RSP_DEPTH), so the
// queue can never overflow. RAM read data returns one cycle after grant.
//   clk_i / rst_i                 : clock, synchronous active-high reset
//   pN_req_i / pN_gnt_o           : request handshake, consumed on req&gnt
//   pN_addr_i/we_i/be_i/wdata_i   : request payload
//   pN_rsp_valid_o/ready_i/rdata_o: read response channel
//   ram_addr_o/we_o/be_o/din_o    : RAM pins, mirror granted request
//   ram_dout_i                    : RAM read data
module rl_ram_1rw_arb
  import rl_ram_arb_pkg::*;
#(
  parameter  int ABITS     = 10,
  parameter  int DBITS     = 32,
  parameter  int RSP_DEPTH = 2,
  localparam int BEW       = be_w(DBITS),
  localparam int CW        = cnt_w(RSP_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             p0_req_i,
  output logic             p0_gnt_o,
  input  logic [ABITS-1:0] p0_addr_i,
  input  logic             p0_we_i,
  input  logic [BEW-1:0]   p0_be_i,
  input  logic [DBITS-1:0] p0_wdata_i,
  output logic             p0_rsp_valid_o,
  input  logic             p0_rsp_ready_i,
  output logic [DBITS-1:0] p0_rsp_rdata_o,
  input  logic             p1_req_i,
  output logic             p1_gnt_o,
  input  logic [ABITS-1:0] p1_addr_i,
  input  logic             p1_we_i,
  input  logic [BEW-1:0]   p1_be_i,
  input  logic [DBITS-1:0] p1_wdata_i,
  output logic             p1_rsp_valid_o,
  input  logic             p1_rsp_ready_i,
  output logic [DBITS-1:0] p1_rsp_rdata_o,
  output logic [ABITS-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic [BEW-1:0]   ram_be_o,
  output logic [DBITS-1:0] ram_din_o,
  input  logic [DBITS-1:0] ram_dout_i
);

  localparam logic [CW:0] DEPTH_C = (CW+1)'(RSP_DEPTH);

  logic [NUM_PORTS-1:0]            req, we, rsp_rdy, rsp_vld;
  logic [NUM_PORTS-1:0]            ok, gnt, inflight, rq_push, rq_pop;
  logic [NUM_PORTS-1:0][ABITS-1:0] addr;
  logic [NUM_PORTS-1:0][BEW-1:0]   be;
  logic [NUM_PORTS-1:0][DBITS-1:0] wdata, rdata;
  logic [NUM_PORTS-1:0][CW-1:0]    cnt;
  port_idx_t                       ptr, win;

  assign req     = {p1_req_i, p0_req_i};
  assign we      = {p1_we_i, p0_we_i};
  assign rsp_rdy = {p1_rsp_ready_i, p0_rsp_ready_i};
  assign addr    = {p1_addr_i, p0_addr_i};
  assign be      = {p1_be_i, p0_be_i};
  assign wdata   = {p1_wdata_i, p0_wdata_i};

  assign p0_gnt_o       = gnt[0];
  assign p1_gnt_o       = gnt[1];
  assign p0_rsp_valid_o = rsp_vld[0];
  assign p1_rsp_valid_o = rsp_vld[1];
  assign p0_rsp_rdata_o = rdata[0];
  assign p1_rsp_rdata_o = rdata[1];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    // Writes need no response slot; reads need one reserved in the queue.
    assign ok[i] = req[i] &
                   (we[i] | (({1'b0, cnt[i]} + (CW+1)'(inflight[i])) < DEPTH_C));

    rl_ram_arb_rspq #(.DBITS(DBITS), .DEPTH(RSP_DEPTH)) u_rspq (
      .clk_i      (clk_i),
      .clr_i      (rst_i),
      .in_vld_i   (inflight[i]),
      .in_data_i  (ram_dout_i),
      .out_rdy_i  (rsp_rdy[i]),
      .out_vld_o  (rsp_vld[i]),
      .out_data_o (rdata[i]),
      .push_o     (rq_push[i]),
      .pop_o      (rq_pop[i]),
      .count_o    (cnt[i])
    );
  end

  always_comb begin
    gnt = '0;
    win = 1'b0;
    if (!rst_i) begin
      unique case (ok)
        2'b01:   win = 1'b0;
        2'b10:   win = 1'b1;
        2'b11:   win = ptr;
        default: win = 1'b0;
      endcase
      gnt[win] = |ok;
    end
  end

  always_comb begin
    ram_addr_o = '0;
    ram_we_o   = 1'b0;
    ram_be_o   = '0;
    ram_din_o  = '0;
    if (|gnt) begin
      ram_addr_o = addr[win];
      ram_we_o   = we[win];
      ram_be_o   = be[win];
      ram_din_o  = wdata[win];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= 1'b0;
      inflight <= '0;
    end else begin
      inflight <= gnt & ~we;
      if (|gnt) ptr <= ~win;
    end
  end

endmodule

// File: tb/tb_rl_ram_1rw_arb.sv
module tb_rl_ram_1rw_arb;
  localparam int ABITS = 10;
  localparam int DBITS = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             p0_req = 0, p0_we = 0, p0_rdy = 0, p1_req = 0, p1_we = 0, p1_rdy = 0;
  logic [ABITS-1:0] p0_addr = '0, p1_addr = '0;
  logic [3:0]       p0_be = '0, p1_be = '0;
  logic [31:0]      p0_wd = '0, p1_wd = '0;
  logic             p0_gnt, p1_gnt, p0_vld, p1_vld, ram_we;
  logic [31:0]      p0_rd, p1_rd, ram_din, ram_dout;
  logic [ABITS-1:0] ram_addr;
  logic [3:0]       ram_be;

  rl_ram_1rw_arb #(.ABITS(ABITS), .DBITS(DBITS), .RSP_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_gnt_o(p0_gnt), .p0_addr_i(p0_addr), .p0_we_i(p0_we),
    .p0_be_i(p0_be), .p0_wdata_i(p0_wd), .p0_rsp_valid_o(p0_vld),
    .p0_rsp_ready_i(p0_rdy), .p0_rsp_rdata_o(p0_rd),
    .p1_req_i(p1_req), .p1_gnt_o(p1_gnt), .p1_addr_i(p1_addr), .p1_we_i(p1_we),
    .p1_be_i(p1_be), .p1_wdata_i(p1_wd), .p1_rsp_valid_o(p1_vld),
    .p1_rsp_ready_i(p1_rdy), .p1_rsp_rdata_o(p1_rd),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_be_o(ram_be),
    .ram_din_o(ram_din), .ram_dout_i(ram_dout)
  );

  // Stand-in single-port RAM: registered read, one-cycle latency.
  logic [31:0] ram_mem [1024];
  always @(posedge clk) begin
    logic [31:0] w;
    w = ram_mem[ram_addr];
    for (int b = 0; b < 4; b++) if (ram_be[b]) w[8*b +: 8] = ram_din[8*b +: 8];
    if (ram_we) begin
      ram_mem[ram_addr] <= w;
      ram_dout          <= w;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  function automatic logic [31:0] f(input logic [9:0] a);
    return 32'hC0DE0000 | {22'd0, a};
  endfunction

  typedef struct {
    logic        rst;
    logic [1:0]  req, we, rdy;
    logic [9:0]  a0, a1;
    logic [3:0]  be0;
    logic [31:0] d0;
    logic [1:0]  egnt, evld;
    logic [31:0] er0, er1;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [1:0] req, we, rdy,
                             input logic [9:0] a0, input logic [3:0] be0,
                             input logic [31:0] d0, input logic [9:0] a1,
                             input logic [1:0] eg, ev, input logic [31:0] e0, e1);
    vec_t x;
    x.rst = r; x.req = req; x.we = we; x.rdy = rdy; x.a0 = a0; x.a1 = a1;
    x.be0 = be0; x.d0 = d0; x.egnt = eg; x.evld = ev; x.er0 = e0; x.er1 = e1;
    return x;
  endfunction

  // Reference model: memory image, per-port queue of owed read words,
  // round-robin preference.
  logic [31:0] mmem [1024];
  logic [31:0] q0[$], q1[$];
  logic        mptr = 1'b0;
  int          n_vec = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(input vec_t x, input bit use_tbl, input logic [3:0] be1,
                       input logic [31:0] d1);
    logic [1:0]  ok, eg, hv;
    logic [31:0] hd0, hd1, m;
    logic        w;
    rst = x.rst;
    p0_req = x.req[0]; p0_we = x.we[0]; p0_rdy = x.rdy[0];
    p0_addr = x.a0; p0_be = x.be0; p0_wd = x.d0;
    p1_req = x.req[1]; p1_we = x.we[1]; p1_rdy = x.rdy[1];
    p1_addr = x.a1; p1_be = be1; p1_wd = d1;
    @(negedge clk);
    ok[0] = x.req[0] & (x.we[0] | (q0.size() < DEPTH));
    ok[1] = x.req[1] & (x.we[1] | (q1.size() < DEPTH));
    eg = 2'b00;
    if (!x.rst) begin
      if (ok == 2'b11) eg[mptr] = 1'b1;
      else eg = ok;
    end
    w = eg[1];
    hv  = {q1.size() > 0, q0.size() > 0};
    hd0 = (q0.size() > 0) ? q0[0] : 32'd0;
    hd1 = (q1.size() > 0) ? q1[0] : 32'd0;

    chk("gnt", 32'({p1_gnt, p0_gnt}), 32'(eg));
    chk("ram_we", 32'(ram_we), 32'(|(eg & x.we)));
    if (eg != 0) chk("ram_addr", 32'(ram_addr), w ? 32'(x.a1) : 32'(x.a0));
    if ((eg & x.we) != 0) begin
      chk("ram_be", 32'(ram_be), w ? 32'(be1) : 32'(x.be0));
      chk("ram_din", ram_din, w ? d1 : x.d0);
    end
    if (!x.rst) begin
      chk("vld", 32'({p1_vld, p0_vld}), 32'(hv));
      if (hv[0]) chk("rdata0", p0_rd, hd0);
      if (hv[1]) chk("rdata1", p1_rd, hd1);
    end
    if (use_tbl) begin
      chk("tbl_gnt", 32'({p1_gnt, p0_gnt}), 32'(x.egnt));
      chk("tbl_vld", 32'({p1_vld, p0_vld}), 32'(x.evld));
      if (x.evld[0]) chk("tbl_rdata0", p0_rd, x.er0);
      if (x.evld[1]) chk("tbl_rdata1", p1_rd, x.er1);
    end

    if (x.rst) begin
      q0.delete(); q1.delete(); mptr = 1'b0;
    end else begin
      if (hv[0] && x.rdy[0]) void'(q0.pop_front());
      if (hv[1] && x.rdy[1]) void'(q1.pop_front());
      if (eg != 0) begin
        if (w ? x.we[1] : x.we[0]) begin
          m = mmem[w ? x.a1 : x.a0];
          for (int b = 0; b < 4; b++)
            if ((w ? be1[b] : x.be0[b])) m[8*b +: 8] = (w ? d1[8*b +: 8] : x.d0[8*b +: 8]);
          mmem[w ? x.a1 : x.a0] = m;
        end else if (w) begin
          q1.push_back(mmem[x.a1]);
        end else begin
          q0.push_back(mmem[x.a0]);
        end
        mptr = ~w;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[33];
    vec_t r;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = f(10'(i));
      mmem[i]    = f(10'(i));
    end
    //                rst req  we   rdy  a0     be0  d0            a1     egnt evld er0             er1
    tbl[0]  = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b00, 0, 0);
    tbl[1]  = v(0, 2'b01, 2'b01, 2'b11, 10'h005, 4'hF, 32'hDEADBEEF, 10'h000, 2'b01, 2'b00, 0, 0);
    tbl[2]  = v(0, 2'b01, 2'b00, 2'b11, 10'h005, 4'hF, 32'h0,        10'h000, 2'b01, 2'b00, 0, 0);
    tbl[3]  = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, 32'hDEADBEEF, 0);
    tbl[4]  = v(1, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b00, 0, 0);
    tbl[5]  = v(0, 2'b11, 2'b00, 2'b11, 10'h100, 4'hF, 32'h0,        10'h200, 2'b01, 2'b00, 0, 0);
    tbl[6]  = v(0, 2'b11, 2'b00, 2'b11, 10'h101, 4'hF, 32'h0,        10'h200, 2'b10, 2'b01, f(10'h100), 0);
    tbl[7]  = v(0, 2'b11, 2'b00, 2'b11, 10'h101, 4'hF, 32'h0,        10'h201, 2'b01, 2'b10, 0, f(10'h200));
    tbl[8]  = v(0, 2'b11, 2'b00, 2'b11, 10'h102, 4'hF, 32'h0,        10'h201, 2'b10, 2'b01, f(10'h101), 0);
    tbl[9]  = v(0, 2'b11, 2'b00, 2'b11, 10'h102, 4'hF, 32'h0,        10'h202, 2'b01, 2'b10, 0, f(10'h201));
    tbl[10] = v(0, 2'b11, 2'b00, 2'b11, 10'h103, 4'hF, 32'h0,        10'h202, 2'b10, 2'b01, f(10'h102), 0);
    tbl[11] = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b10, 0, f(10'h202));
    // p0 backpressure: third read must wait for a credit
    tbl[12] = v(0, 2'b01, 2'b00, 2'b10, 10'h010, 4'hF, 32'h0,        10'h000, 2'b01, 2'b00, 0, 0);
    tbl[13] = v(0, 2'b01, 2'b00, 2'b10, 10'h011, 4'hF, 32'h0,        10'h000, 2'b01, 2'b01, f(10'h010), 0);
    tbl[14] = v(0, 2'b01, 2'b00, 2'b10, 10'h012, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, f(10'h010), 0);
    tbl[15] = v(0, 2'b01, 2'b00, 2'b10, 10'h012, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, f(10'h010), 0);
    tbl[16] = v(0, 2'b01, 2'b00, 2'b11, 10'h012, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, f(10'h010), 0);
    tbl[17] = v(0, 2'b01, 2'b00, 2'b11, 10'h012, 4'hF, 32'h0,        10'h000, 2'b01, 2'b01, f(10'h011), 0);
    tbl[18] = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, f(10'h012), 0);
    // byte-enable merge
    tbl[19] = v(0, 2'b01, 2'b01, 2'b11, 10'h020, 4'hF, 32'hFFFFFFFF, 10'h000, 2'b01, 2'b00, 0, 0);
    tbl[20] = v(0, 2'b01, 2'b01, 2'b11, 10'h020, 4'b0100, 32'h00AB0000, 10'h000, 2'b01, 2'b00, 0, 0);
    tbl[21] = v(0, 2'b01, 2'b00, 2'b11, 10'h020, 4'hF, 32'h0,        10'h000, 2'b01, 2'b00, 0, 0);
    tbl[22] = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, 32'hFFABFFFF, 0);
    // reset right after a p1 read grant; requests during reset are ignored
    tbl[23] = v(0, 2'b10, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h030, 2'b10, 2'b00, 0, 0);
    tbl[24] = v(1, 2'b11, 2'b00, 2'b01, 10'h040, 4'hF, 32'h0,        10'h050, 2'b00, 2'b10, 0, f(10'h030));
    tbl[25] = v(0, 2'b11, 2'b00, 2'b11, 10'h040, 4'hF, 32'h0,        10'h050, 2'b01, 2'b00, 0, 0);
    tbl[26] = v(0, 2'b11, 2'b00, 2'b11, 10'h041, 4'hF, 32'h0,        10'h050, 2'b10, 2'b01, f(10'h040), 0);
    tbl[27] = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b10, 0, f(10'h050));
    // pointer left at p1 by a p0 grant must return to p0 on reset
    tbl[28] = v(0, 2'b01, 2'b01, 2'b11, 10'h060, 4'hF, 32'h12345678, 10'h000, 2'b01, 2'b00, 0, 0);
    tbl[29] = v(1, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b00, 0, 0);
    tbl[30] = v(0, 2'b11, 2'b00, 2'b11, 10'h061, 4'hF, 32'h0,        10'h070, 2'b01, 2'b00, 0, 0);
    tbl[31] = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b01, f(10'h061), 0);
    tbl[32] = v(0, 2'b00, 2'b00, 2'b11, 10'h000, 4'hF, 32'h0,        10'h000, 2'b00, 2'b00, 0, 0);

    @(posedge clk);
    #1;
    r = v(1, 2'b00, 2'b00, 2'b00, 10'h0, 4'h0, 32'h0, 10'h0, 2'b00, 2'b00, 0, 0);
    apply(r, 0, 4'h0, 32'h0);
    apply(r, 0, 4'h0, 32'h0);

    for (int i = 0; i < 33; i++) apply(tbl[i], 1, 4'hF, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r.rst  = ($urandom_range(0, 99) == 0);
      r.req  = 2'($urandom_range(0, 3));
      r.we   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      r.rdy  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      r.a0   = 10'($urandom_range(0, 15));
      r.a1   = 10'($urandom_range(0, 15));
      r.be0  = 4'($urandom_range(0, 15));
      r.d0   = $urandom;
      apply(r, 0, 4'($urandom_range(0, 15)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
